// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue controller: holds one fetched instruction, checks its
// sources against a per-register pending-writeback scoreboard and issues it
// to execute over a valid/ready handshake when no RAW hazard exists.
module decode_issue_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                if_valid_i,
  output logic                if_ready_o,
  input  logic [31:0]         instr_i,
  input  logic [4:0]          rs1_i,
  input  logic [4:0]          rs2_i,
  input  logic [4:0]          rd_i,
  input  logic                use_rs1_i,
  input  logic                use_rs2_i,
  input  logic                wr_rd_i,
  output logic                issue_valid_o,
  input  logic                issue_ready_i,
  output logic [31:0]         instr_o,
  output logic [4:0]          rd_o,
  output logic                wr_rd_o,
  input  logic                wb_valid_i,
  input  logic [4:0]          wb_rd_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic                wb_err_o
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int RW = 5;

  // Decode slot contents
  logic          held_valid_q, held_valid_d;
  logic [31:0]   instr_q, instr_d;
  logic [RW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic          use_rs1_q, use_rs1_d, use_rs2_q, use_rs2_d, wr_rd_q, wr_rd_d;

  // Outstanding-write scoreboard; entry 0 is never incremented, so it stays 0
  logic [CW-1:0] cnt_q [NUM_REGS];
  logic [CW-1:0] cnt_d [NUM_REGS];
  logic          wb_err_q, wb_err_d;

  logic hazard, issue, accept, wb_dec;

  // Hazard check and handshake, using only the registered counters
  always_comb begin
    hazard = (use_rs1_q && (rs1_q != '0) && (cnt_q[rs1_q] != '0)) ||
             (use_rs2_q && (rs2_q != '0) && (cnt_q[rs2_q] != '0)) ||
             (wr_rd_q   && (rd_q  != '0) && (cnt_q[rd_q] == CW'(MAX_INFLIGHT)));
    issue_valid_o = held_valid_q && !hazard && !flush_i;
    stall_o       = held_valid_q && hazard;
    issue         = issue_valid_o && issue_ready_i;
    if_ready_o    = !held_valid_q || issue || flush_i;
    accept        = if_valid_i && if_ready_o;
    wb_dec        = wb_valid_i && (wb_rd_i != '0) && (cnt_q[wb_rd_i] != '0);
  end

  // Slot next state: flush wins and drops any same-cycle accept
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the branches leaves it unassigned and infers a latch.
    held_valid_d = held_valid_q;
    instr_d      = instr_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    use_rs1_d    = use_rs1_q;
    use_rs2_d    = use_rs2_q;
    wr_rd_d      = wr_rd_q;
    if (flush_i) begin
      held_valid_d = 1'b0;
    end else if (accept) begin
      held_valid_d = 1'b1;
      instr_d      = instr_i;
      rs1_d        = rs1_i;
      rs2_d        = rs2_i;
      rd_d         = rd_i;
      use_rs1_d    = use_rs1_i;
      use_rs2_d    = use_rs2_i;
      wr_rd_d      = wr_rd_i;
    end else if (issue) begin
      held_valid_d = 1'b0;
    end
  end

  // Counter next state: +1 on issuing a write, -1 on a legal writeback
  always_comb begin
    cnt_d    = cnt_q;
    wb_err_d = wb_err_q || (wb_valid_i && (wb_rd_i != '0) && (cnt_q[wb_rd_i] == '0));
    for (int r = 1; r < NUM_REGS; r++) begin
      if ((issue && wr_rd_q && (rd_q == RW'(r))) && !(wb_dec && (wb_rd_i == RW'(r))))
        cnt_d[r] = cnt_q[r] + CW'(1);
      else if (!(issue && wr_rd_q && (rd_q == RW'(r))) && (wb_dec && (wb_rd_i == RW'(r))))
        cnt_d[r] = cnt_q[r] - CW'(1);
    end
  end

  // Slot registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      held_valid_q <= 1'b0;
      instr_q      <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      use_rs1_q    <= 1'b0;
      use_rs2_q    <= 1'b0;
      wr_rd_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of its inputs regardless of statement order.
      held_valid_q <= held_valid_d;
      instr_q      <= instr_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      use_rs1_q    <= use_rs1_d;
      use_rs2_q    <= use_rs2_d;
      wr_rd_q      <= wr_rd_d;
    end
  end

  // Scoreboard registers and sticky error flag
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: the counter array is reset, unlike a data RAM, because a stale
      // count would create a phantom hazard or a false writeback error.
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      wb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wb_err_q <= wb_err_d;
    end
  end

  // Output view of the held instruction and the scoreboard
  always_comb begin
    instr_o   = instr_q;
    rd_o      = rd_q;
    wr_rd_o   = wr_rd_q;
    wb_err_o  = wb_err_q;
    pending_o = '0;
    for (int r = 1; r < NUM_REGS; r++) pending_o[r] = (cnt_q[r] != '0);
  end

endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Decode-stage issue controller for the in-order pipeline. It holds one fetched instruction in the decode slot and checks its source registers against a per-register scoreboard of pending writebacks. It issues the instruction to execute with a valid/ready handshake only when no read-after-write hazard exists. It stalls fetch otherwise and drains the held instruction on a pipeline flush. The immediate generator and register file read the instruction word it presents on `instr_o`.

## Interface

Parameters:
- `NUM_REGS`, 32, number of architectural integer registers; x0 is never tracked.
- `MAX_INFLIGHT`, 3, maximum outstanding writes per register; counter width is `$clog2(MAX_INFLIGHT+1)`.

Ports:
- `clk_i` in 1: the single clock; all state updates on its rising edge.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `if_valid_i` in 1: fetch presents an instruction.
- `if_ready_o` out 1: decode slot accepts this cycle.
- `instr_i` in 32: fetched instruction word.
- `rs1_i`, `rs2_i`, `rd_i` in 5 each: register indices pre-extracted from `instr_i`.
- `use_rs1_i`, `use_rs2_i`, `wr_rd_i` in 1 each: instruction reads rs1 / reads rs2 / writes rd.
- `issue_valid_o` out 1: held instruction is offered to execute.
- `issue_ready_i` in 1: execute accepts.
- `instr_o` out 32: held instruction word.
- `rd_o` out 5: held rd.
- `wr_rd_o` out 1: held write flag.
- `wb_valid_i` in 1: a register write retires this cycle.
- `wb_rd_i` in 5: retiring destination.
- `flush_i` in 1: kill the held, unissued instruction.
- `stall_o` out 1: held instruction blocked by a hazard.
- `pending_o` out `NUM_REGS`: bit r = counter[r] != 0.
- `wb_err_o` out 1: sticky; writeback to a register with a zero counter.

## Operation

- State: `held_valid`, held fields (instr, rs1, rs2, rd, flags), counters `cnt[1..NUM_REGS-1]`, `wb_err`.
- Slot states:
  - EMPTY (`held_valid=0`).
  - HELD (valid, no hazard, waiting on `issue_ready_i`).
  - STALLED (valid, hazard).
- Hazard, evaluated from registered counters only:
  - `use_rs1 && rs1!=0 && cnt[rs1]!=0`, or
  - the same condition for rs2, or
  - `wr_rd && rd!=0 && cnt[rd]==MAX_INFLIGHT`.
- `issue_valid_o = held_valid && !hazard && !flush_i`.
- `stall_o = held_valid && hazard`.
- `issue = issue_valid_o && issue_ready_i`.
- `if_ready_o = !held_valid || issue || flush_i`.
- Accept (`if_valid_i && if_ready_o`): load the slot next edge.
- Flush cycle:
  - the slot is cleared;
  - any instruction accepted in the same cycle is dropped;
  - the slot is EMPTY next cycle.
- Flush leaves counters untouched: issued instructions always retire through writeback.
- Counter update per register r != 0:
  - +1 on issue with `wr_rd && rd==r`.
  - -1 on `wb_valid_i && wb_rd_i==r && cnt[r]!=0`.
  - Both in the same cycle on the same r: net unchanged.
- Writeback with `wb_rd_i==0`: ignored.
- Writeback to r with `cnt[r]==0`:
  - the counter stays 0;
  - `wb_err_o` sets and holds until reset.
- A counter never exceeds `MAX_INFLIGHT`; the saturation hazard guarantees it.
- Held fields persist unchanged while STALLED or HELD.

## Timing

- Reset (async assert, sync release on the clock edge):
  - `held_valid=0`, all counters 0, `wb_err_o=0`.
  - Hence `issue_valid_o=0`, `stall_o=0`, `pending_o=0`, `if_ready_o=1`.
  - `instr_o=0`, `rd_o=0`, `wr_rd_o=0`.
- Latency:
  - An instruction accepted at edge N is offered from cycle N+1 (one-cycle decode).
  - Back-to-back issue is 1 instruction/cycle when there are no hazards.
- Writeback visibility: a writeback at cycle C clears a hazard only from cycle C+1. There is no same-cycle bypass.
- Dependent back-to-back pair: the consumer stalls until the cycle after its producer's writeback.
- Reset asserted mid-operation: all state clears immediately. Any in-flight counts are lost; a later writeback then sets `wb_err_o`, which is expected and is not masked.
- `issue_ready_i` low with no hazard: the slot holds, `stall_o=0`, `if_ready_o=0`.

## Test plan

- Reset, then 4 independent ALU ops (rd=1..4, no sources) with `issue_ready_i=1` -> 4 issues on consecutive cycles; `pending_o` shows bits 1-4 set; no stall.
- Issue a write to x5, then a reader of x5 (rs1=5); writeback x5 at cycle C -> `stall_o=1` until C; issue at C+1; `pending_o[5]` clears at C+1.
- Three unretired writes to x7, then a fourth writer of x7 -> the fourth stalls (`cnt=3`). One writeback -> it issues next cycle; `cnt` stays 3. Issue and writeback on x7 in the same cycle -> `cnt` is unchanged.
- Held STALLED instruction with `flush_i=1` and `if_valid_i=1` together -> `issue_valid_o=0` that cycle; slot EMPTY next cycle; counters unchanged; the new instruction is dropped.
- Writeback to x9 with `cnt[9]=0` -> `wb_err_o=1` and stays 1. A writeback to x0 or an op with rd=0 -> no counter change and no error.
- Assert `rstn_i` mid-stall with a nonzero `pending_o` -> all outputs reach reset values asynchronously, before the next edge.
